// File: rtl/trap_controller_if.sv
// Core-to-trap-controller bus: the commit-stage trap request, the CSR
// read/write port, and the stall/redirect controls going back to the pipeline.
interface trap_controller_if #(
  parameter int XLEN = 32
) ();
  logic            inst_valid;
  logic [1:0]      trap;
  logic [XLEN-1:0] pc;
  logic            ext_irq;
  logic [11:0]     csr_raddr;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_we;
  logic [11:0]     csr_waddr;
  logic [XLEN-1:0] csr_wdata;
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output inst_valid, trap, pc, ext_irq, csr_raddr, csr_we, csr_waddr, csr_wdata,
    input  csr_rdata, stall, redirect_valid, redirect_pc
  );

  modport slave (
    input  inst_valid, trap, pc, ext_irq, csr_raddr, csr_we, csr_waddr, csr_wdata,
    output csr_rdata, stall, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/trap_controller.sv
// Machine-mode trap sequencer: owns mstatus/mtvec/mepc/mcause, arbitrates
// interrupts, sync traps and mret, stalls the core and issues one PC redirect.
module trap_controller #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] IRQ_CAUSE = 32'h8000000B
) (
  input logic               clk,
  input logic               rst,
  trap_controller_if.slave  bus
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

  localparam logic [1:0] TRAP_ECALL   = 2'b01;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b10;
  localparam logic [1:0] TRAP_MRET    = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    SAVE,
    VECTOR,
    RETURN
  } state_t;

  state_t          state_q, state_d;
  logic            mie_q, mie_d;
  logic            mpie_q, mpie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

  logic idle;
  logic irq_take;
  logic sync_take;
  logic mret_take;
  logic trap_take;

  // Event arbitration: interrupt beats sync trap beats mret, all gated on commit.
  always_comb begin
    idle      = (state_q == IDLE);
    irq_take  = idle & bus.inst_valid & bus.ext_irq & mie_q;
    sync_take = idle & bus.inst_valid & ~irq_take &
                ((bus.trap == TRAP_ECALL) | (bus.trap == TRAP_ILLEGAL));
    mret_take = idle & bus.inst_valid & ~irq_take & (bus.trap == TRAP_MRET);
    trap_take = irq_take | sync_take;
  end

  always_comb begin
    state_d          = state_q;
    mie_d            = mie_q;
    mpie_d           = mpie_q;
    mtvec_d          = mtvec_q;
    mepc_d           = mepc_q;
    mcause_d         = mcause_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;

    case (state_q)
      IDLE: begin
        if (trap_take) begin
          mepc_d  = {bus.pc[XLEN-1:2], 2'b00};
          if (irq_take)
            mcause_d = IRQ_CAUSE;
          else if (bus.trap == TRAP_ECALL)
            mcause_d = XLEN'(32'd11);
          else
            mcause_d = XLEN'(32'd2);
          state_d = SAVE;
        end else if (mret_take) begin
          mie_d            = mpie_q;
          mpie_d           = 1'b1;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = mepc_q;
          state_d          = RETURN;
        end else if (bus.csr_we) begin
          // Writes only land on a quiet IDLE cycle; unknown addresses fall through.
          case (bus.csr_waddr)
            ADDR_MSTATUS: begin
              mie_d  = bus.csr_wdata[3];
              mpie_d = bus.csr_wdata[7];
            end
            ADDR_MTVEC:  mtvec_d  = {bus.csr_wdata[XLEN-1:2], 2'b00};
            ADDR_MEPC:   mepc_d   = {bus.csr_wdata[XLEN-1:2], 2'b00};
            ADDR_MCAUSE: mcause_d = bus.csr_wdata;
            default: ;
          endcase
        end
      end
      SAVE: begin
        mpie_d           = mie_q;
        mie_d            = 1'b0;
        redirect_valid_d = 1'b1;
        redirect_pc_d    = mtvec_q;
        state_d          = VECTOR;
      end
      VECTOR:  state_d = IDLE;
      RETURN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      mie_q            <= 1'b0;
      mpie_q           <= 1'b0;
      mtvec_q          <= '0;
      mepc_q           <= '0;
      mcause_q         <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      state_q          <= state_d;
      mie_q            <= mie_d;
      mpie_q           <= mpie_d;
      mtvec_q          <= mtvec_d;
      mepc_q           <= mepc_d;
      mcause_q         <= mcause_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  always_comb begin
    bus.csr_rdata = '0;
    case (bus.csr_raddr)
      ADDR_MSTATUS: begin
        bus.csr_rdata[3] = mie_q;
        bus.csr_rdata[7] = mpie_q;
      end
      ADDR_MTVEC:  bus.csr_rdata = mtvec_q;
      ADDR_MEPC:   bus.csr_rdata = mepc_q;
      ADDR_MCAUSE: bus.csr_rdata = mcause_q;
      default: ;
    endcase
  end

  assign bus.stall          = ~idle | trap_take | mret_take;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_trap_controller.sv
// Self-checking bench for trap_controller: directed scenarios plus random
// traffic checked cycle by cycle against a schedule-based reference model.
module tb_trap_controller;

  logic clk;
  logic rst;

  trap_controller_if #(.XLEN(32)) bus ();

  trap_controller #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: architectural CSR values plus a schedule of future
  // actions (deferred status save, expected redirect) keyed by cycle number.
  logic        m_mie, m_mpie;
  logic [31:0] m_mtvec, m_mepc, m_mcause;
  int          cyc;
  int          busy_until;
  int          save_cyc;
  int          rv_cyc;
  logic [31:0] rv_pc;

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: m_read = {24'd0, m_mpie, 3'd0, m_mie, 3'd0};
      12'h305: m_read = m_mtvec;
      12'h341: m_read = m_mepc;
      12'h342: m_read = m_mcause;
      default: m_read = 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_mie = 1'b0; m_mpie = 1'b0;
    m_mtvec = 32'd0; m_mepc = 32'd0; m_mcause = 32'd0;
    busy_until = cyc;
    save_cyc = -1;
    rv_cyc = -1;
    rv_pc = 32'd0;
  endtask

  task automatic step(input logic r, input logic iv, input logic [1:0] tr,
                      input logic [31:0] p, input logic irq, input logic we,
                      input logic [11:0] wa, input logic [31:0] wd, input logic [11:0] ra,
                      output logic [31:0] o_rd, output logic o_st,
                      output logic o_rv, output logic [31:0] o_rpc);
    logic idle, t_irq, t_sync, t_mret, take;
    @(negedge clk);
    rst = r;
    bus.inst_valid = iv; bus.trap = tr; bus.pc = p; bus.ext_irq = irq;
    bus.csr_we = we; bus.csr_waddr = wa; bus.csr_wdata = wd; bus.csr_raddr = ra;
    #1;
    o_rd = bus.csr_rdata; o_st = bus.stall; o_rv = bus.redirect_valid; o_rpc = bus.redirect_pc;

    idle   = (cyc > busy_until);
    t_irq  = idle && iv && irq && m_mie;
    t_sync = idle && iv && !t_irq && (tr == 2'b01 || tr == 2'b10);
    t_mret = idle && iv && !t_irq && (tr == 2'b11);
    take   = t_irq || t_sync || t_mret;

    if (!r) begin
      chk("stall", {31'd0, o_st}, {31'd0, idle ? take : 1'b1});
      chk("redirect_valid", {31'd0, o_rv}, {31'd0, cyc == rv_cyc});
      if (cyc == rv_cyc) chk("redirect_pc", o_rpc, rv_pc);
      chk("csr_rdata", o_rd, m_read(ra));
    end

    if (r) begin
      model_reset();
    end else begin
      if (cyc == save_cyc) begin
        m_mpie = m_mie;
        m_mie  = 1'b0;
      end
      if (t_irq || t_sync) begin
        m_mepc     = p & ~32'd3;
        m_mcause   = t_irq ? 32'h8000000B : (tr == 2'b01 ? 32'd11 : 32'd2);
        save_cyc   = cyc + 1;
        rv_cyc     = cyc + 2;
        rv_pc      = m_mtvec;
        busy_until = cyc + 2;
      end else if (t_mret) begin
        rv_cyc     = cyc + 1;
        rv_pc      = m_mepc;
        busy_until = cyc + 1;
        m_mie      = m_mpie;
        m_mpie     = 1'b1;
      end else if (idle && we) begin
        case (wa)
          12'h300: begin m_mie = wd[3]; m_mpie = wd[7]; end
          12'h305: m_mtvec  = wd & ~32'd3;
          12'h341: m_mepc   = wd & ~32'd3;
          12'h342: m_mcause = wd;
          default: ;
        endcase
      end
    end
    @(posedge clk);
    cyc++;
  endtask

  function automatic logic [11:0] pick_addr();
    case ($urandom_range(0, 4))
      0: pick_addr = 12'h300;
      1: pick_addr = 12'h305;
      2: pick_addr = 12'h341;
      3: pick_addr = 12'h342;
      default: pick_addr = 12'($urandom);
    endcase
  endfunction

  logic [31:0] rd, rpc;
  logic        st, rv;

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0;
    rst = 1'b1;
    bus.inst_valid = 1'b0; bus.trap = 2'b00; bus.pc = '0; bus.ext_irq = 1'b0;
    bus.csr_we = 1'b0; bus.csr_waddr = '0; bus.csr_wdata = '0; bus.csr_raddr = '0;
    model_reset();

    // Reset and basic CSR access
    step(1, 0, 2'b00, 0, 0, 0, 0, 0, 12'h300, rd, st, rv, rpc);
    step(1, 0, 2'b00, 0, 0, 0, 0, 0, 12'h300, rd, st, rv, rpc);
    step(0, 0, 2'b00, 0, 0, 0, 0, 0, 12'h300, rd, st, rv, rpc);
    chk("rst_mstatus", rd, 32'd0); chk("rst_stall", {31'd0, st}, 32'd0);
    chk("rst_redirect", {31'd0, rv}, 32'd0); chk("rst_redirect_pc", rpc, 32'd0);
    step(0, 0, 2'b00, 0, 0, 1, 12'h305, 32'h103, 12'h305, rd, st, rv, rpc);
    chk("mtvec_old_on_write", rd, 32'd0);
    step(0, 0, 2'b00, 0, 0, 0, 0, 0, 12'h305, rd, st, rv, rpc);
    chk("mtvec_masked", rd, 32'h100);
    step(0, 0, 2'b00, 0, 0, 0, 0, 0, 12'h341, rd, st, rv, rpc); chk("rst_mepc", rd, 32'd0);
    step(0, 0, 2'b00, 0, 0, 0, 0, 0, 12'h342, rd, st, rv, rpc); chk("rst_mcause", rd, 32'd0);

    // ecall sequence
    step(0, 1, 2'b01, 32'h40, 0, 0, 0, 0, 12'h341, rd, st, rv, rpc);
    chk("ecall_stall_T", {31'd0, st}, 32'd1);
    step(0, 0, 2'b00, 0, 0, 0, 0, 0, 12'h341, rd, st, rv, rpc);
    chk("ecall_mepc", rd, 32'h40); chk("ecall_stall_T1", {31'd0, st}, 32'd1);
    step(0, 0, 2'b00, 0, 0, 0, 0, 0, 12'h342, rd, st, rv, rpc);
    chk("ecall_mcause", rd, 32'd11); chk("ecall_rv", {31'd0, rv}, 32'd1);
    chk("ecall_rpc", rpc, 32'h100);
    step(0, 0, 2'b00, 0, 0, 0, 0, 0, 12'h300, rd, st, rv, rpc);
    chk("ecall_done_stall", {31'd0, st}, 32'd0); chk("ecall_rv_off", {31'd0, rv}, 32'd0);

    // mret sequence
    step(0, 0, 2'b00, 0, 0, 1, 12'h300, 32'h8, 12'h300, rd, st, rv, rpc);
    step(0, 0, 2'b00, 0, 0, 1, 12'h341, 32'h44, 12'h300, rd, st, rv, rpc);
    chk("mstatus_mie", rd, 32'h8);
    step(0, 1, 2'b11, 32'h200, 0, 0, 0, 0, 12'h300, rd, st, rv, rpc);
    chk("mret_stall_T", {31'd0, st}, 32'd1);
    step(0, 0, 2'b00, 0, 0, 0, 0, 0, 12'h300, rd, st, rv, rpc);
    chk("mret_mstatus", rd, 32'h80); chk("mret_rv", {31'd0, rv}, 32'd1);
    chk("mret_rpc", rpc, 32'h44);
    step(0, 0, 2'b00, 0, 0, 0, 0, 0, 12'h300, rd, st, rv, rpc);
    chk("mret_done_stall", {31'd0, st}, 32'd0);

    // Interrupt beats illegal, then the same with MIE clear
    step(0, 0, 2'b00, 0, 0, 1, 12'h300, 32'h8, 12'h300, rd, st, rv, rpc);
    step(0, 1, 2'b10, 32'h80, 1, 0, 0, 0, 12'h300, rd, st, rv, rpc);
    step(0, 0, 2'b00, 0, 1, 0, 0, 0, 12'h342, rd, st, rv, rpc);
    chk("irq_mcause", rd, 32'h8000000B);
    step(0, 0, 2'b00, 0, 1, 0, 0, 0, 12'h300, rd, st, rv, rpc);
    chk("irq_mstatus", rd, 32'h80);
    step(0, 0, 2'b00, 0, 0, 0, 0, 0, 12'h341, rd, st, rv, rpc);
    chk("irq_mepc", rd, 32'h80);
    step(0, 1, 2'b10, 32'h84, 1, 0, 0, 0, 12'h300, rd, st, rv, rpc);
    step(0, 0, 2'b00, 0, 0, 0, 0, 0, 12'h342, rd, st, rv, rpc);
    chk("masked_irq_mcause", rd, 32'd2);
    step(0, 0, 2'b00, 0, 0, 0, 0, 0, 12'h300, rd, st, rv, rpc);
    step(0, 0, 2'b00, 0, 0, 0, 0, 0, 12'h300, rd, st, rv, rpc);

    // Writes dropped while a trap is taken, and to an unmapped address
    step(0, 1, 2'b01, 32'h90, 0, 1, 12'h341, 32'h555, 12'h341, rd, st, rv, rpc);
    step(0, 0, 2'b00, 0, 0, 0, 0, 0, 12'h341, rd, st, rv, rpc);
    chk("drop_write_mepc", rd, 32'h90);
    step(0, 0, 2'b00, 0, 0, 0, 0, 0, 12'h300, rd, st, rv, rpc);
    step(0, 0, 2'b00, 0, 0, 1, 12'h123, 32'hFFFF_FFFF, 12'h123, rd, st, rv, rpc);
    step(0, 0, 2'b00, 0, 0, 0, 0, 0, 12'h123, rd, st, rv, rpc);
    chk("unmapped_read", rd, 32'd0);
    step(0, 0, 2'b00, 0, 0, 0, 0, 0, 12'h305, rd, st, rv, rpc);
    chk("unmapped_no_side_effect", rd, 32'h100);

    // Reset during SAVE aborts the sequence
    step(0, 1, 2'b10, 32'h60, 0, 0, 0, 0, 12'h300, rd, st, rv, rpc);
    step(1, 0, 2'b00, 0, 0, 0, 0, 0, 12'h300, rd, st, rv, rpc);
    step(0, 0, 2'b00, 0, 0, 0, 0, 0, 12'h341, rd, st, rv, rpc);
    chk("abort_rv", {31'd0, rv}, 32'd0); chk("abort_stall", {31'd0, st}, 32'd0);
    chk("abort_mepc", rd, 32'd0);
    step(0, 0, 2'b00, 0, 0, 0, 0, 0, 12'h342, rd, st, rv, rpc);
    chk("abort_mcause", rd, 32'd0); chk("abort_rv2", {31'd0, rv}, 32'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic        r_r, r_iv, r_irq, r_we;
      logic [1:0]  r_tr;
      r_r   = ($urandom_range(0, 99) == 0);
      r_iv  = ($urandom_range(0, 9) != 0);
      r_tr  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      r_irq = ($urandom_range(0, 3) == 0);
      r_we  = ($urandom_range(0, 2) == 0);
      step(r_r, r_iv, r_tr, $urandom, r_irq, r_we, pick_addr(), $urandom, pick_addr(),
           rd, st, rv, rpc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
